mcoi_diag_rs485_tx: RTL and testbench
=====================================

// Module: mcoi_diag_rs485_tx
// PURPOSE
//  Telemetry serialiser downstream of the board diagnostics block (McoiXu5Diagnostics).
//  Snapshots temperature, power, PCB revision and unique ID, and frames them as 15 UART bytes.
//  Transmits 8N1 on the half-duplex RS485 line (rs485_pl_ro), with driver-enable control.
//  Sends periodically, or on request.
// PARAMETERS
//  CLK_FREQ_HZ    100_000_000  clk frequency; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division)
//  BAUD           115_200      line rate, bits/s
//  PERIOD_CYCLES  10_000_000   clk cycles between automatic frame starts; 0 = periodic sending off
// PORTS
//  clk            in   1   system clock
//  rst            in   1   async reset, active-high
//  temp_ib16      in   16  temperature from diagnostics
//  power_ib16     in   16  power from diagnostics
//  rev_ib4        in   4   PCB revision
//  id_ib64        in   64  unique ID
//  send_i         in   1   1-cycle request pulse for an immediate frame
//  tx_o           out  1   UART data to RS485 driver; idle high
//  de_o           out  1   RS485 driver enable
//  busy_o         out  1   high from frame start to end of trailing guard
//  frame_cnt_ob16 out  16  count of completed frames
// BEHAVIOUR
//  Reset (async, all outputs): tx_o=1, de_o=0, busy_o=0, frame_cnt_ob16=0; period timer=0; pending=0.
//  Frame layout, big-endian, 15 bytes:
//    A5 | {4'h0,rev} | temp[15:8] temp[7:0] | power[15:8] power[7:0] | id[63:56]..id[7:0] | CHK
//  Input snapshot: all inputs are registered on the start cycle; later input changes do not affect the frame.
//  Start conditions, checked in IDLE:
//   - send_i seen, or pending set;
//   - or the period timer reaches PERIOD_CYCLES-1.
//  Period timer: clears at every frame start; counts in all states.
//  FSM: IDLE -> LEAD -> START -> DATA -> STOP, then next byte (START) or, after byte 14, TRAIL -> IDLE.
//   - LEAD: de_o=1, tx_o=1, lasts 1 bit.
//   - START: tx_o=0, 1 bit.
//   - DATA: 8 bits, LSB first.
//   - STOP: tx_o=1, 1 bit.
//   - TRAIL: de_o=1, tx_o=1, 1 bit.
//   - Each bit lasts exactly CLKS_PER_BIT cycles.
//   - No idle gap between bytes.
//  Frame length: 152 bit times.
//   - de_o and busy_o rise in the cycle after the start condition and fall on the TRAIL->IDLE transition.
//  Completion: frame_cnt increments on the TRAIL->IDLE transition; wraps FFFF->0000.
//  Request while busy: send_i when busy_o=1 sets a 1-deep pending flag.
//   - Further requests merge into it.
//   - The pending frame starts the cycle after IDLE is re-entered.
//  Simultaneous requests: if send_i and the period timer expire in the same cycle, one frame is sent.
//  Reset mid-frame: line returns to idle immediately (tx_o=1, de_o=0); no partial-frame recovery.
// CONFIGURATION
//  MCOI_DIAG_CRC8_EN defined:
//   - CHK = CRC-8 over bytes 0..13, MSB-first bitwise.
//   - Poly 0x07, init 0x00, no reflection, no xorout.
//   - Computed one bit per cycle while the byte is shifted out.
//  MCOI_DIAG_CRC8_EN undefined: CHK = sum of bytes 0..13 mod 256.
//  Frame length and timing are identical in both builds.
// STRUCTURE
//  McoiDiagPkg (shared package):
//   - SYNC_BYTE=8'hA5, FRAME_LEN=15;
//   - typedef enum diag_tx_state_t {IDLE,LEAD,START,DATA,STOP,TRAIL};
//   - function crc8_step().
//  Sub-module mcoi_uart_tx_bitgen:
//   - bit-period counter and 10-bit shift register;
//   - load/ready handshake: load accepted only when ready=1; ready rises in the last cycle of STOP.
//  Top level: frame sequencer, snapshot register, checksum, period timer, pending flag, DE/guard control.
// TESTING (bench: CLK_FREQ_HZ=1_000_000, BAUD=100_000 -> 10 clk/bit, PERIOD_CYCLES=0 unless stated)
//  1 Single frame.
//    - Stimulus: temp=1234, power=0056, rev=3, id=0102030405060708, pulse send_i.
//    - Decoded bytes: A5 03 12 34 00 56 01 02 03 04 05 06 07 08 68.
//    - de_o high for exactly 1520 cycles; frame_cnt=1.
//  2 CRC build.
//    - Same stimulus as test 1, MCOI_DIAG_CRC8_EN defined.
//    - Byte 14 equals the reference-model CRC-8/0x07 of bytes 0..13; other bytes unchanged.
//  3 Snapshot integrity.
//    - Change temp to FFFF 50 cycles after send_i.
//    - Frame still carries 12 34; the next requested frame carries FF FF.
//  4 Pending merge.
//    - Three send_i pulses during a busy frame.
//    - Exactly 2 frames total; second LEAD starts 1 cycle after first TRAIL ends; frame_cnt=2.
//  5 Periodic sending.
//    - PERIOD_CYCLES=2000, no send_i, run 10000 cycles.
//    - Frame starts at cycles 2000, 4000, 6000, 8000.
//    - Same-cycle send_i at 4000 yields a single frame.
//  6 Async reset.
//    - Assert rst at cycle 700 of a frame.
//    - Same cycle: tx_o=1, de_o=0, busy_o=0, frame_cnt=0.
//    - After release, send_i yields a clean full frame.

Source files
------------

// File: rtl/mcoi_diag_rs485_tx_pkg.sv
// Shared definitions for the diagnostics RS485 telemetry serialiser.
package mcoi_diag_rs485_tx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 15;

  typedef enum logic [2:0] {IDLE, LEAD, START, DATA, STOP, TRAIL} diag_tx_state_t;

  // One MSB-first step of CRC-8, poly 0x07.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? 8'h07 : 8'h00);
  endfunction

endpackage

// File: rtl/mcoi_uart_tx_bitgen.sv
// 8N1 bit generator: bit-period counter and 10-bit shift register, idle high.
// A byte loaded in the last STOP cycle follows with no idle gap.
module mcoi_uart_tx_bitgen
  import mcoi_diag_rs485_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic             active;
  logic [9:0]       shreg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign ready   = !active || (bit_idx == 4'd9 && bit_end);
  assign tx      = shreg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '1;
      cnt     <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
    end else if (load && ready) begin
      shreg   <= {1'b1, data, 1'b0};
      cnt     <= '0;
      bit_idx <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (bit_end) begin
        cnt   <= '0;
        // Shifting in ones leaves the line idle high once the stop bit ends.
        shreg <= {1'b1, shreg[9:1]};
        if (bit_idx == 4'd9) active  <= 1'b0;
        else                 bit_idx <= bit_idx + 4'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mcoi_diag_rs485_tx.sv
// Diagnostics telemetry frame sender on RS485 (15-byte frame, driver-enable guard bits).
// Define MCOI_DIAG_CRC8_EN for a CRC-8 check byte; otherwise an 8-bit sum is sent.
module mcoi_diag_rs485_tx
  import mcoi_diag_rs485_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
  parameter int unsigned BAUD          = 115_200,
  parameter int unsigned PERIOD_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] temp_ib16,
  input  logic [15:0] power_ib16,
  input  logic [3:0]  rev_ib4,
  input  logic [63:0] id_ib64,
  input  logic        send_i,
  output logic        tx_o,
  output logic        de_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_ob16
);

  localparam int unsigned CPB       = CLK_FREQ_HZ / BAUD;
  localparam int          CNT_W     = $clog2(CPB + 1);
  localparam logic [3:0]  LAST_BYTE = 4'(FRAME_LEN - 1);
  localparam logic [31:0] PER_M1    = (PERIOD_CYCLES == 0) ? 32'd0 : 32'(PERIOD_CYCLES - 1);

  diag_tx_state_t    state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_idx;
  logic [3:0]        byte_idx, nxt_idx;
  logic              pending;
  logic [31:0]       tmr;
  logic [15:0]       snap_temp, snap_power;
  logic [3:0]        snap_rev;
  logic [63:0]       snap_id;
  logic [0:13][7:0]  hdr;
  logic [7:0]        chk, nxt_byte;
  logic              bit_end, period_hit, start, load, bg_ready;

  assign bit_end    = (clk_cnt == CNT_W'(CPB - 1));
  assign period_hit = (PERIOD_CYCLES != 0) && (tmr == PER_M1);
  assign start      = (state == IDLE) && (send_i || pending || period_hit);

  assign hdr      = {SYNC_BYTE, 4'h0, snap_rev, snap_temp, snap_power, snap_id};
  assign nxt_idx  = (state == LEAD) ? 4'd0 : byte_idx + 4'd1;
  assign nxt_byte = (nxt_idx == LAST_BYTE) ? chk : hdr[nxt_idx];
  // Next byte is handed over in the final cycle of LEAD or of a non-final STOP.
  assign load     = ((state == LEAD) || (state == STOP && byte_idx != LAST_BYTE)) && bit_end && bg_ready;

  mcoi_uart_tx_bitgen #(.CLKS_PER_BIT(CPB)) u_bitgen (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .data  (nxt_byte),
    .ready (bg_ready),
    .tx    (tx_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      byte_idx       <= '0;
      de_o           <= 1'b0;
      busy_o         <= 1'b0;
      frame_cnt_ob16 <= '0;
      pending        <= 1'b0;
      tmr            <= '0;
      snap_temp      <= '0;
      snap_power     <= '0;
      snap_rev       <= '0;
      snap_id        <= '0;
    end else begin
      tmr <= start ? 32'd0 : tmr + 32'd1;
      if (start)                pending <= 1'b0;
      else if (send_i && busy_o) pending <= 1'b1;

      case (state)
        IDLE: if (start) begin
          state      <= LEAD;
          de_o       <= 1'b1;
          busy_o     <= 1'b1;
          clk_cnt    <= '0;
          snap_temp  <= temp_ib16;
          snap_power <= power_ib16;
          snap_rev   <= rev_ib4;
          snap_id    <= id_ib64;
        end
        default: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + CNT_W'(1);
          if (bit_end) begin
            case (state)
              LEAD:  begin state <= START; byte_idx <= '0; end
              START: begin state <= DATA;  bit_idx  <= '0; end
              DATA:  if (bit_idx == 3'd7) state <= STOP;
                     else                 bit_idx <= bit_idx + 3'd1;
              STOP:  if (byte_idx == LAST_BYTE) state <= TRAIL;
                     else begin state <= START; byte_idx <= byte_idx + 4'd1; end
              TRAIL: begin
                state          <= IDLE;
                de_o           <= 1'b0;
                busy_o         <= 1'b0;
                frame_cnt_ob16 <= frame_cnt_ob16 + 16'd1;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

`ifdef MCOI_DIAG_CRC8_EN
  logic [7:0] crc_sh;
  logic [3:0] crc_cnt;

  // Each byte is folded in MSB-first over 8 cycles, well inside its 10-bit slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk     <= '0;
      crc_sh  <= '0;
      crc_cnt <= '0;
    end else if (start) begin
      chk     <= '0;
      crc_cnt <= '0;
    end else if (load && nxt_idx != LAST_BYTE) begin
      crc_sh  <= nxt_byte;
      crc_cnt <= 4'd8;
    end else if (crc_cnt != 4'd0) begin
      chk     <= crc8_step(chk, crc_sh[7]);
      crc_sh  <= {crc_sh[6:0], 1'b0};
      crc_cnt <= crc_cnt - 4'd1;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 chk <= '0;
    else if (start)                          chk <= '0;
    else if (load && nxt_idx != LAST_BYTE)   chk <= chk + nxt_byte;
  end
`endif

endmodule

// File: tb/tb_mcoi_diag_rs485_tx.sv
// Bench for mcoi_diag_rs485_tx: frames decoded from the line and compared with a byte-level model.
module tb_mcoi_diag_rs485_tx;

  localparam int unsigned CLKF = 1_000_000;
  localparam int unsigned BAUD = 100_000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] temp, power;
  logic [3:0]  rev;
  logic [63:0] id;
  logic        send;
  logic        tx, de, busy, tx_p, de_p, busy_p;
  logic [15:0] fc, fc_p;

  int checks = 0;
  int errors = 0;

  logic         rec [0:1599];
  logic [119:0] got_v;
  int           de_len, gap;
  bit           cap_ok;

  always #5 clk = ~clk;

  mcoi_diag_rs485_tx #(.CLK_FREQ_HZ(CLKF), .BAUD(BAUD), .PERIOD_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .temp_ib16(temp), .power_ib16(power), .rev_ib4(rev),
    .id_ib64(id), .send_i(send), .tx_o(tx), .de_o(de), .busy_o(busy), .frame_cnt_ob16(fc));

  mcoi_diag_rs485_tx #(.CLK_FREQ_HZ(CLKF), .BAUD(BAUD), .PERIOD_CYCLES(2000)) dut_p (
    .clk(clk), .rst(rst), .temp_ib16(temp), .power_ib16(power), .rev_ib4(rev),
    .id_ib64(id), .send_i(send), .tx_o(tx_p), .de_o(de_p), .busy_o(busy_p), .frame_cnt_ob16(fc_p));

  // Expected frame bytes built from the frame layout; byte 0 in the top 8 bits.
  function automatic logic [119:0] model_frame(input logic [15:0] t, input logic [15:0] p,
                                               input logic [3:0] r, input logic [63:0] i_d);
    logic [7:0]   b [15];
    logic [7:0]   c;
    logic [119:0] v;
    b[0] = 8'hA5; b[1] = {4'h0, r};
    b[2] = t[15:8]; b[3] = t[7:0]; b[4] = p[15:8]; b[5] = p[7:0];
    for (int i = 0; i < 8; i++) b[6+i] = i_d[63-8*i -: 8];
    c = 8'h00;
`ifdef MCOI_DIAG_CRC8_EN
    for (int i = 0; i < 14; i++)
      for (int k = 7; k >= 0; k--) begin
        logic fb;
        fb = c[7] ^ b[i][k];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
`else
    for (int i = 0; i < 14; i++) c = c + b[i];
`endif
    b[14] = c;
    for (int i = 0; i < 15; i++) v[119-8*i -: 8] = b[i];
    return v;
  endfunction

  task automatic pulse_send();
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    temp  = 16'($urandom());
    power = 16'($urandom());
    rev   = 4'($urandom());
    id    = {$urandom(), $urandom()};
  endtask

  // Line monitor: waits (bounded) for de, records tx each de-high cycle, decodes mid-bit.
  task automatic capture();
    int t = 0;
    cap_ok = 1'b1; de_len = 0; got_v = 'x;
    while (de !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    gap = t;
    if (de !== 1'b1) begin cap_ok = 1'b0; return; end
    while (de === 1'b1 && de_len < 1600) begin rec[de_len] = tx; de_len++; @(negedge clk); end
    if (de_len != 1520) begin cap_ok = 1'b0; return; end
    if (rec[5] !== 1'b1 || rec[1515] !== 1'b1) cap_ok = 1'b0;
    for (int k = 0; k < 15; k++) begin
      int base;
      logic [7:0] b;
      base = 10 + 100 * k;
      if (rec[base+5] !== 1'b0 || rec[base+95] !== 1'b1) cap_ok = 1'b0;
      for (int j = 0; j < 8; j++) b[j] = rec[base + 10*(j+1) + 5];
      got_v[119-8*k -: 8] = b;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (de !== 1'b0)     begin errors++; $display("FAIL reset_de got %b want 0", de); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fc !== 16'h0000) begin errors++; $display("FAIL reset_fc got %h want 0000", fc); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    logic [119:0] exp_v;
    temp = 16'h1234; power = 16'h0056; rev = 4'h3; id = 64'h0102030405060708;
    exp_v = model_frame(temp, power, rev, id);
    fork pulse_send(); capture(); join
    checks++; if (!cap_ok) begin errors++; $display("FAIL single_framing de_len %0d want 1520 ok %b", de_len, cap_ok); end
    checks++; if (got_v !== exp_v) begin errors++; $display("FAIL single_bytes got %h want %h", got_v, exp_v); end
    checks++; if (de_len != 1520) begin errors++; $display("FAIL single_de_len got %0d want 1520", de_len); end
    checks++; if (fc !== 16'd1) begin errors++; $display("FAIL single_fc got %0d want 1", fc); end
  endtask

  task automatic test_checksum();
    logic [119:0] exp_v;
    exp_v = model_frame(temp, power, rev, id);
    repeat (5) @(negedge clk);
    fork pulse_send(); capture(); join
    checks++;
    if (got_v[119:8] !== 112'hA5031234005601020304050607_08) begin
      errors++; $display("FAIL chk_body got %h want a5031234005601020304050607 08", got_v[119:8]);
    end
    checks++;
    if (got_v[7:0] !== exp_v[7:0]) begin
      errors++; $display("FAIL chk_byte got %h want %h", got_v[7:0], exp_v[7:0]);
    end
  endtask

  task automatic test_snapshot();
    logic [119:0] exp1, exp2;
    exp1 = model_frame(16'h1234, power, rev, id);
    exp2 = model_frame(16'hFFFF, power, rev, id);
    repeat (5) @(negedge clk);
    fork
      pulse_send();
      capture();
      begin repeat (50) @(negedge clk); temp = 16'hFFFF; end
    join
    checks++; if (got_v !== exp1) begin errors++; $display("FAIL snap_first got %h want %h", got_v, exp1); end
    repeat (5) @(negedge clk);
    fork pulse_send(); capture(); join
    checks++; if (got_v !== exp2) begin errors++; $display("FAIL snap_second got %h want %h", got_v, exp2); end
  endtask

  task automatic test_back_to_back();
    logic [119:0] exp_v, f1;
    int len1, rises;
    bit ok1;
    do_reset();
    randomize_inputs();
    exp_v = model_frame(temp, power, rev, id);
    fork
      begin
        pulse_send();
        for (int n = 0; n < 3; n++) begin
          repeat ($urandom_range(50, 400)) @(negedge clk);
          pulse_send();
        end
      end
      begin
        capture(); f1 = got_v; len1 = de_len; ok1 = cap_ok;
        capture();
      end
    join
    checks++; if (!ok1 || f1 !== exp_v) begin errors++; $display("FAIL b2b_first got %h want %h len %0d", f1, exp_v, len1); end
    checks++; if (!cap_ok || got_v !== exp_v) begin errors++; $display("FAIL b2b_second got %h want %h len %0d", got_v, exp_v, de_len); end
    checks++; if (gap != 1) begin errors++; $display("FAIL b2b_gap got %0d want 1 idle cycle", gap); end
    rises = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (de === 1'b1) rises++;
    end
    checks++; if (rises != 0) begin errors++; $display("FAIL b2b_extra_frame de_cycles %0d want 0", rises); end
    checks++; if (fc !== 16'd2) begin errors++; $display("FAIL b2b_fc got %0d want 2", fc); end
  endtask

  task automatic test_random();
    logic [119:0] exp_v;
    for (int n = 0; n < 3; n++) begin
      randomize_inputs();
      exp_v = model_frame(temp, power, rev, id);
      fork
        pulse_send();
        capture();
        begin repeat ($urandom_range(2, 1400)) @(negedge clk); randomize_inputs(); end
      join
      checks++; if (!cap_ok || got_v !== exp_v) begin errors++; $display("FAIL random_%0d got %h want %h", n, got_v, exp_v); end
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end
  endtask

  task automatic test_periodic();
    int starts[$];
    int want[4] = '{2000, 4000, 6000, 8000};
    logic prev;
    do_reset();
    prev = 1'b0;
    for (int c = 1; c < 10000; c++) begin
      @(negedge clk);
      if (de_p === 1'b1 && prev === 1'b0) starts.push_back(c);
      prev = de_p;
      send = (c == 3999);
    end
    send = 1'b0;
    checks++; if (starts.size() != 4) begin errors++; $display("FAIL periodic_count got %0d want 4", starts.size()); end
    for (int i = 0; i < 4 && i < starts.size(); i++) begin
      checks++;
      if (starts[i] != want[i]) begin errors++; $display("FAIL periodic_start_%0d got %0d want %0d", i, starts[i], want[i]); end
    end
    checks++; if (fc_p !== 16'd4) begin errors++; $display("FAIL periodic_fc got %0d want 4", fc_p); end
  endtask

  task automatic test_async_reset();
    logic [119:0] exp_v;
    do_reset();
    randomize_inputs();
    pulse_send();
    repeat (699) @(negedge clk);
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL arst_pre_de got %b want 1", de); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL arst_tx got %b want 1", tx); end
    checks++; if (de !== 1'b0)   begin errors++; $display("FAIL arst_de got %b want 0", de); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    checks++; if (fc !== 16'd0)  begin errors++; $display("FAIL arst_fc got %0d want 0", fc); end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    randomize_inputs();
    exp_v = model_frame(temp, power, rev, id);
    fork pulse_send(); capture(); join
    checks++; if (!cap_ok || got_v !== exp_v) begin errors++; $display("FAIL arst_frame got %h want %h len %0d", got_v, exp_v, de_len); end
    checks++; if (fc !== 16'd1) begin errors++; $display("FAIL arst_fc_after got %0d want 1", fc); end
  endtask

  initial begin
    rst = 1'b1; send = 1'b0;
    temp = '0; power = '0; rev = '0; id = '0;
    test_reset();
    test_single();
    test_checksum();
    test_snapshot();
    test_back_to_back();
    test_random();
    test_periodic();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
